// File: rtl/tlb_pkg.sv
//============================================================================
// Module : tlb_pkg
// Brief  : Shared types for the TLB op sequencer slice.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package tlb_pkg;

  localparam int TLB_IDX_BITS = 4;

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } tlb_seq_state_t;

  function automatic logic is_tlb_write(input tlb_op_t op);
    return (op == TLBWI) || (op == TLBWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlb_random_counter.sv
//============================================================================
// Module : tlb_random_counter
// Brief  : CP0 Random register; counts down to Wired, reloads at the top.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tlb_random_counter #(
  parameter int IDX_BITS = 4,
  parameter int TLB_NUM  = 1 << IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic                wired_we,
  input  logic [IDX_BITS-1:0] wired,
  output logic [IDX_BITS-1:0] random
);

  localparam logic [IDX_BITS-1:0] c_random_max = IDX_BITS'(TLB_NUM - 1);

  logic [IDX_BITS-1:0] r_random;
  logic [IDX_BITS-1:0] w_random_next;

  // Reload also covers wired >= max, which pins Random at the top entry.
  always_comb begin
    w_random_next = r_random;
    if (!hold) begin
      if (wired_we || (r_random <= wired)) w_random_next = c_random_max;
      else                                 w_random_next = r_random - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_random <= c_random_max;
    else        r_random <= w_random_next;
  end

  assign random = r_random;

endmodule

`default_nettype wire

// File: rtl/tlb_op_sequencer.sv
//============================================================================
// Module : tlb_op_sequencer
// Brief  : Sequences TLBP/TLBR/TLBWI/TLBWR against the shared TLB array.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tlb_op_sequencer
  import tlb_pkg::*;
#(
  parameter int IDX_BITS = TLB_IDX_BITS,
  parameter int TLB_NUM  = 1 << IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  input  logic [1:0]          op_type,
  output logic                op_ready,
  input  logic                op_kill,
  output logic                op_done,
  output logic                stall,
  input  logic [31:0]         cp0_index,
  input  logic [IDX_BITS-1:0] cp0_wired,
  input  logic                cp0_wired_we,
  output logic [IDX_BITS-1:0] cp0_random,
  output logic                tlb_we,
  output logic [31:0]         tlb_index,
  input  logic [31:0]         tlb_probe_index,
  output logic                cp0_index_we,
  output logic [31:0]         cp0_index_wdata,
  output logic                cp0_tlbr_we,
  output logic                itlb_flush
);

  tlb_seq_state_t      r_state;
  tlb_seq_state_t      w_next_state;
  tlb_op_t             r_op;
  logic [IDX_BITS-1:0] r_idx;
  logic [31:0]         r_probe;
  logic                w_accept;
  logic                w_unused_index_bits;

  assign w_unused_index_bits = ^cp0_index[31:IDX_BITS];
  assign w_accept            = op_valid && (r_state == IDLE);

  tlb_random_counter #(
    .IDX_BITS (IDX_BITS),
    .TLB_NUM  (TLB_NUM)
  ) u_random (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (r_state == EXEC),
    .wired_we (cp0_wired_we),
    .wired    (cp0_wired),
    .random   (cp0_random)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SETTLE;
      SETTLE:  w_next_state = op_kill ? IDLE : EXEC;
      EXEC:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // TLBWR samples Random before any same-cycle Wired write reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= TLBP;
      r_idx   <= '0;
      r_probe <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op  <= tlb_op_t'(op_type);
        r_idx <= (tlb_op_t'(op_type) == TLBWR) ? cp0_random : cp0_index[IDX_BITS-1:0];
      end
      if ((r_state == EXEC) && (r_op == TLBP)) r_probe <= tlb_probe_index;
    end
  end

  assign op_ready        = (r_state == IDLE);
  assign stall           = w_accept || (r_state != IDLE);
  assign tlb_we          = (r_state == EXEC) && is_tlb_write(r_op);
  assign cp0_tlbr_we     = (r_state == EXEC) && (r_op == TLBR);
  assign op_done         = (r_state == DONE);
  assign cp0_index_we    = (r_state == DONE) && (r_op == TLBP);
  assign itlb_flush      = (r_state == DONE) && is_tlb_write(r_op);
  assign cp0_index_wdata = r_probe;
  assign tlb_index       = (r_state != IDLE) ? {{(32-IDX_BITS){1'b0}}, r_idx} : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_tlb_op_sequencer.sv
//============================================================================
// Module : tb_tlb_op_sequencer
// Brief  : Scoreboard bench for tlb_op_sequencer with directed op vectors.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_tlb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [1:0]  op_type;
  logic        op_ready;
  logic        op_kill;
  logic        op_done;
  logic        stall;
  logic [31:0] cp0_index;
  logic [3:0]  cp0_wired;
  logic        cp0_wired_we;
  logic [3:0]  cp0_random;
  logic        tlb_we;
  logic [31:0] tlb_index;
  logic [31:0] tlb_probe_index;
  logic        cp0_index_we;
  logic [31:0] cp0_index_wdata;
  logic        cp0_tlbr_we;
  logic        itlb_flush;

  tlb_op_sequencer #(.IDX_BITS(4), .TLB_NUM(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .op_valid        (op_valid),
    .op_type         (op_type),
    .op_ready        (op_ready),
    .op_kill         (op_kill),
    .op_done         (op_done),
    .stall           (stall),
    .cp0_index       (cp0_index),
    .cp0_wired       (cp0_wired),
    .cp0_wired_we    (cp0_wired_we),
    .cp0_random      (cp0_random),
    .tlb_we          (tlb_we),
    .tlb_index       (tlb_index),
    .tlb_probe_index (tlb_probe_index),
    .cp0_index_we    (cp0_index_we),
    .cp0_index_wdata (cp0_index_wdata),
    .cp0_tlbr_we     (cp0_tlbr_we),
    .itlb_flush      (itlb_flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] idx;
    logic        done;
    logic        flush;
    logic        iwe;
    logic [31:0] wdata;
    logic        rwe;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push_ev(input int c, input logic we, input logic [31:0] idx, input logic done,
                         input logic flush, input logic iwe, input logic [31:0] wd, input logic rwe);
    ev_t e;
    e.cyc = c; e.we = we; e.idx = idx; e.done = done;
    e.flush = flush; e.iwe = iwe; e.wdata = wd; e.rwe = rwe;
    exp_q.push_back(e);
  endtask

  // Monitor: any strobe on the output side must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (tlb_we || op_done || cp0_index_we || cp0_tlbr_we || itlb_flush)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: cyc=%0d we=%b idx=%0h done=%b flush=%b iwe=%b rwe=%b required none",
                 cyc, tlb_we, tlb_index, op_done, itlb_flush, cp0_index_we, cp0_tlbr_we);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || tlb_we !== e.we || tlb_index !== e.idx || op_done !== e.done ||
            itlb_flush !== e.flush || cp0_index_we !== e.iwe || cp0_tlbr_we !== e.rwe ||
            (e.iwe && cp0_index_wdata !== e.wdata)) begin
          miscompares++;
          $display("FAIL event: got cyc=%0d we=%b idx=%0h done=%b flush=%b iwe=%b wdata=%0h rwe=%b required cyc=%0d we=%b idx=%0h done=%b flush=%b iwe=%b wdata=%0h rwe=%b",
                   cyc, tlb_we, tlb_index, op_done, itlb_flush, cp0_index_we, cp0_index_wdata, cp0_tlbr_we,
                   e.cyc, e.we, e.idx, e.done, e.flush, e.iwe, e.wdata, e.rwe);
        end
      end
    end
  end

  // Called at a negedge in IDLE; returns at the SETTLE negedge.
  task automatic issue_op(input logic [1:0] t, input logic [31:0] idx_exp,
                          input logic [31:0] probe, input bit expect_events);
    int a;
    tlb_probe_index = probe;
    op_valid = 1'b1;
    op_type  = t;
    a = cyc;
    if (expect_events) begin
      case (t)
        2'd0: push_ev(a + 3, 1'b0, idx_exp, 1'b1, 1'b0, 1'b1, probe, 1'b0);
        2'd1: begin
          push_ev(a + 2, 1'b0, idx_exp, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
          push_ev(a + 3, 1'b0, idx_exp, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        end
        default: begin
          push_ev(a + 2, 1'b1, idx_exp, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
          push_ev(a + 3, 1'b0, idx_exp, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        end
      endcase
    end
    #1 chk("stall_at_accept", {31'd0, stall}, 32'd1);
    @(negedge clk);
    op_valid     = 1'b0;
    cp0_wired_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_type = 2'd0; op_kill = 1'b0;
    cp0_index = 32'd0; cp0_wired = 4'd3; cp0_wired_we = 1'b0; tlb_probe_index = 32'd0;
    repeat (2) @(negedge clk);

    chk("reset_op_ready", {31'd0, op_ready}, 32'd1);
    chk("reset_random", {28'd0, cp0_random}, 32'd15);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_tlb_we", {31'd0, tlb_we}, 32'd0);
    chk("reset_tlb_index", tlb_index, 32'd0);
    chk("reset_wdata", cp0_index_wdata, 32'd0);
    rst_n = 1'b1;

    // Wired=3: Random walks 15..3 then reloads to 15.
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("random_walk_%0d", k), {28'd0, cp0_random},
          (k < 13) ? 32'(15 - k) : 32'(15 - (k - 13)));
      @(negedge clk);
    end

    // TLBWR takes the Random value of the accept cycle (8).
    issue_op(2'd3, 32'd8, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("random_after_wr", {28'd0, cp0_random}, 32'd5);
    @(negedge clk);
    chk("random_before_wired_wr", {28'd0, cp0_random}, 32'd4);

    // Wired write in the TLBWR accept cycle: old Random used, reload after.
    cp0_wired = 4'd10; cp0_wired_we = 1'b1;
    issue_op(2'd3, 32'd4, 32'd0, 1'b1);
    chk("random_reload_on_wired_we", {28'd0, cp0_random}, 32'd15);
    repeat (3) @(negedge clk);

    cp0_index = 32'hABC0_0005;
    issue_op(2'd2, 32'd5, 32'd0, 1'b1);
    repeat (3) @(negedge clk);

    cp0_index = 32'd0;
    issue_op(2'd0, 32'd0, 32'h0000_0007, 1'b1);
    repeat (3) @(negedge clk);
    issue_op(2'd0, 32'd0, 32'h8000_0000, 1'b1);
    repeat (3) @(negedge clk);

    cp0_index = 32'd2;
    issue_op(2'd1, 32'd2, 32'd0, 1'b1);
    repeat (3) @(negedge clk);

    // Kill in SETTLE: no strobes, back to IDLE next cycle.
    cp0_index = 32'd6;
    issue_op(2'd2, 32'd6, 32'd0, 1'b0);
    op_kill = 1'b1;
    @(negedge clk);
    op_kill = 1'b0;
    chk("kill_op_ready", {31'd0, op_ready}, 32'd1);
    chk("kill_tlb_index", tlb_index, 32'd0);
    repeat (3) @(negedge clk);

    // Kill in EXEC is too late and must be ignored.
    cp0_index = 32'd11;
    issue_op(2'd2, 32'd11, 32'd0, 1'b1);
    @(negedge clk);
    op_kill = 1'b1;
    @(negedge clk);
    op_kill = 1'b0;
    @(negedge clk);

    // Async reset in EXEC drops the write strobe immediately.
    cp0_index = 32'd12;
    issue_op(2'd2, 32'd12, 32'd0, 1'b0);
    @(posedge clk);
    #1 chk("exec_tlb_we_before_reset", {31'd0, tlb_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_exec_tlb_we", {31'd0, tlb_we}, 32'd0);
    chk("reset_mid_exec_op_ready", {31'd0, op_ready}, 32'd1);
    chk("reset_mid_exec_random", {28'd0, cp0_random}, 32'd15);
    chk("reset_mid_exec_tlb_index", tlb_index, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    cp0_index = 32'd9;
    issue_op(2'd2, 32'd9, 32'd0, 1'b1);
    repeat (5) @(negedge clk);

    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
